// File: rtl/systolic_pkg.sv
// Shared types and sizing for the systolic result-buffer controller.
package systolic_pkg;

    localparam int unsigned DATAWIDTH_output = 32;
    localparam int unsigned N_SIZE           = 32;
    localparam int unsigned ROW_W            = DATAWIDTH_output * N_SIZE;
    localparam int unsigned DEPTH            = 543;
    localparam int unsigned ADDR_WIDTH       = 10;
    localparam int unsigned FIFO_DEPTH       = 2;
    localparam int unsigned FIFO_CNT_W       = 2;
    localparam int unsigned CREDIT_W         = 3;

    typedef logic [ROW_W-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

    // Index of the final row of a tile of n rows (n >= 1).
    function automatic logic [ADDR_WIDTH-1:0] last_row(input logic [ADDR_WIDTH-1:0] n);
        return n - ADDR_WIDTH'(1);
    endfunction

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry row FIFO used as the drain skid; head and count come straight from flops.
module sync_fifo2
    import systolic_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  row_t                  din,
    output row_t                  dout,
    output logic [FIFO_CNT_W-1:0] cnt
);

    row_t                  mem_q [FIFO_DEPTH];
    row_t                  mem_d [FIFO_DEPTH];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [FIFO_CNT_W-1:0] cnt_q, cnt_d;
    logic                  do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        do_push  = push && (cnt_q < FIFO_CNT_W'(FIFO_DEPTH));
        do_pop   = pop && (cnt_q != '0);
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        cnt_d    = cnt_q + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = mem_q[rd_ptr_q];
    assign cnt  = cnt_q;

endmodule

// File: rtl/systolic_buffer_ctrl.sv
// Fills one result buffer from the array for a tile, then drains it in order
// onto a valid/ready stream with credit-limited reads into a 2-entry skid FIFO.
module systolic_buffer_ctrl
    import systolic_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num_rows,
    input  logic                  in_valid,
    input  row_t                  in_data,
    output logic                  buf_we,
    output logic [ADDR_WIDTH-1:0] buf_wr_addr,
    output row_t                  buf_wdata,
    output logic [ADDR_WIDTH-1:0] buf_rd_addr,
    input  row_t                  buf_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output row_t                  out_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    ctrl_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] num_rows_q, num_rows_d;
    logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_WIDTH-1:0] pop_cnt_q, pop_cnt_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  inflight_q, inflight_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  wr_en;
    logic                  issue;
    logic                  pop;
    logic                  credit_ok;
    logic [FIFO_CNT_W-1:0] fifo_cnt;
    row_t                  fifo_dout;

    assign out_valid = (fifo_cnt != '0);
    assign out_data  = fifo_dout;
    assign pop       = out_valid && out_ready;

    // Occupancy after this cycle's pop plus the read in flight must leave room for one more.
    assign credit_ok = (CREDIT_W'(fifo_cnt) + CREDIT_W'(inflight_q))
                       < (CREDIT_W'(FIFO_DEPTH) + CREDIT_W'(pop));

    always_comb begin
        state_d    = state_q;
        num_rows_d = num_rows_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        rd_addr_d  = rd_addr_q;
        err_d      = err_q;
        wr_en      = 1'b0;
        issue      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_rows == '0) begin
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else if (num_rows > ADDR_WIDTH'(DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        num_rows_d = num_rows;
                        wr_cnt_d   = '0;
                        rd_cnt_d   = '0;
                        pop_cnt_d  = '0;
                        err_d      = 1'b0;
                        state_d    = FILL;
                    end
                end
            end
            FILL: begin
                if (in_valid) begin
                    wr_en    = 1'b1;
                    wr_cnt_d = wr_cnt_q + ADDR_WIDTH'(1);
                    if (wr_cnt_q == last_row(num_rows_q)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                issue = (rd_cnt_q < num_rows_q) && credit_ok;
                if (issue) begin
                    rd_addr_d = rd_cnt_q;
                    rd_cnt_d  = rd_cnt_q + ADDR_WIDTH'(1);
                end
                if (pop) begin
                    pop_cnt_d = pop_cnt_q + ADDR_WIDTH'(1);
                    if (pop_cnt_q == last_row(num_rows_q)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A row arriving when the buffer is not filling is dropped and flagged.
        if (in_valid && (state_q != FILL)) begin
            err_d = 1'b1;
        end

        inflight_d = issue;
        busy_d     = (state_d == FILL) || (state_d == DRAIN);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            num_rows_q <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            pop_cnt_q  <= '0;
            rd_addr_q  <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_rows_q <= num_rows_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            rd_addr_q  <= rd_addr_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    sync_fifo2 u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .pop   (pop),
        .din   (buf_rdata),
        .dout  (fifo_dout),
        .cnt   (fifo_cnt)
    );

    assign buf_we      = wr_en;
    assign buf_wr_addr = wr_cnt_q;
    assign buf_wdata   = in_data;
    assign buf_rd_addr = rd_addr_d;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_systolic_buffer_ctrl.sv
// Directed bench for systolic_buffer_ctrl with a behavioural result buffer.
module tb_systolic_buffer_ctrl;
    import systolic_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [ADDR_WIDTH-1:0] num_rows;
    logic                  in_valid;
    row_t                  in_data;
    logic                  buf_we;
    logic [ADDR_WIDTH-1:0] buf_wr_addr;
    row_t                  buf_wdata;
    logic [ADDR_WIDTH-1:0] buf_rd_addr;
    row_t                  buf_rdata;
    logic                  out_valid;
    logic                  out_ready;
    row_t                  out_data;
    logic                  busy;
    logic                  done;
    logic                  err;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_n    = 0;
    int done_cnt = 0;

    row_t mem [DEPTH];
    int   wr_log [$];
    int   wr_cyc [$];
    row_t out_log [$];
    int   out_cyc [$];
    row_t exp_q [$];

    systolic_buffer_ctrl u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_rows    (num_rows),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .buf_we      (buf_we),
        .buf_wr_addr (buf_wr_addr),
        .buf_wdata   (buf_wdata),
        .buf_rd_addr (buf_rd_addr),
        .buf_rdata   (buf_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Buffer model: synchronous write, one-cycle registered read.
    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (buf_we && (int'(buf_wr_addr) < int'(DEPTH))) mem[buf_wr_addr] <= buf_wdata;
        if (int'(buf_rd_addr) < int'(DEPTH)) buf_rdata <= mem[buf_rd_addr];
    end

    always @(negedge clk) begin
        if (buf_we === 1'b1) begin
            wr_log.push_back(int'(buf_wr_addr));
            wr_cyc.push_back(cyc_n);
        end
        if ((out_valid === 1'b1) && (out_ready === 1'b1)) begin
            out_log.push_back(out_data);
            out_cyc.push_back(cyc_n);
        end
        if (done === 1'b1) done_cnt++;
    end

    function automatic row_t mk_row(input int unsigned s);
        row_t r;
        for (int k = 0; k < int'(N_SIZE); k++)
            r[k*DATAWIDTH_output +: DATAWIDTH_output] = 32'(s * 32'h9E37_79B1 + 32'(k) + 32'h55);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input row_t obs, input row_t exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed low64 %0h expected low64 %0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wr_log.delete(); wr_cyc.delete(); out_log.delete(); out_cyc.delete(); exp_q.delete();
        done_cnt = 0;
    endtask

    task automatic start_tile(input int n);
        start    = 1'b1;
        num_rows = ADDR_WIDTH'(n);
        cyc();
        start    = 1'b0;
    endtask

    task automatic feed(input int n, input int unsigned seed, input int gap);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = mk_row(seed + i);
            exp_q.push_back(in_data);
            cyc();
            in_valid = 1'b0;
            repeat (gap) cyc();
        end
    endtask

    task automatic wait_done(input int budget, input bit bp);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            out_ready = bp ? 1'(((i % 4) == 0) || ((i % 4) == 3)) : 1'b1;
            cyc();
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        out_ready = 1'b1;
        chk("done_seen", 32'(ok), 32'd1);
        cyc();
        chk("done_one_cycle", 32'(done), 32'd0);
        cyc();
    endtask

    task automatic cmp_out(input string tag);
        chk({tag, "_out_count"}, 32'(out_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_log.size(); i++)
            chk_row($sformatf("%s_row%0d", tag, i), out_log[i], exp_q[i]);
    endtask

    task automatic cmp_wr(input string tag, input int n);
        chk({tag, "_wr_count"}, 32'(wr_log.size()), 32'(n));
        for (int i = 0; i < n && i < wr_log.size(); i++)
            chk($sformatf("%s_wr_addr%0d", tag, i), 32'(wr_log[i]), 32'(i));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num_rows = '0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b1;
        repeat (3) cyc();

        // Reset state
        chk("rst_buf_we", 32'(buf_we), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wr_addr", 32'(buf_wr_addr), 32'd0);
        chk("rst_rd_addr", 32'(buf_rd_addr), 32'd0);
        chk_row("rst_out_data", out_data, '0);
        rst_n = 1'b1;
        cyc();

        // Basic 4-row tile at full throughput
        clr();
        start_tile(4);
        chk("basic_busy", 32'(busy), 32'd1);
        feed(4, 100, 0);
        wait_done(30, 1'b0);
        cmp_wr("basic", 4);
        cmp_out("basic");
        chk("basic_done_cnt", 32'(done_cnt), 32'd1);
        chk("basic_busy_after", 32'(busy), 32'd0);
        if (out_cyc.size() == 4 && wr_cyc.size() == 4) begin
            chk("basic_first_out_lat", 32'(out_cyc[0] - wr_cyc[3]), 32'd3);
            chk("basic_back_to_back", 32'(out_cyc[3] - out_cyc[0]), 32'd3);
        end else chk("basic_cycle_logs", 32'(out_cyc.size()), 32'd4);

        // Backpressure 8 rows, ready 1,0,0,1,...
        clr();
        start_tile(8);
        feed(8, 200, 0);
        wait_done(100, 1'b1);
        cmp_wr("bp", 8);
        cmp_out("bp");
        chk("bp_done_cnt", 32'(done_cnt), 32'd1);

        // Gapped fill, 3 rows with 2 idle cycles between
        clr();
        start_tile(3);
        feed(3, 300, 2);
        wait_done(30, 1'b0);
        cmp_wr("gap", 3);
        cmp_out("gap");
        if (out_cyc.size() > 0 && wr_cyc.size() == 3)
            chk("gap_first_out_lat", 32'(out_cyc[0] - wr_cyc[2]), 32'd3);
        else chk("gap_cycle_logs", 32'(wr_cyc.size()), 32'd3);

        // Zero-row tile
        clr();
        start_tile(0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        repeat (3) cyc();
        chk("zero_no_writes", 32'(wr_log.size()), 32'd0);
        chk("zero_no_out", 32'(out_log.size()), 32'd0);
        chk("zero_done_cnt", 32'(done_cnt), 32'd1);

        // Full-depth tile
        clr();
        start_tile(543);
        feed(543, 1000, 0);
        wait_done(700, 1'b0);
        chk("full_wr_count", 32'(wr_log.size()), 32'd543);
        if (wr_log.size() > 0) chk("full_last_addr", 32'(wr_log[wr_log.size()-1]), 32'd542);
        cmp_out("full");

        // Oversized tile rejected
        clr();
        start_tile(544);
        chk("over_err", 32'(err), 32'd1);
        chk("over_busy", 32'(busy), 32'd0);
        repeat (3) cyc();
        chk("over_still_idle", 32'(busy), 32'd0);
        chk("over_no_done", 32'(done_cnt), 32'd0);

        // Valid start clears err; start in FILL ignored; in_valid in DRAIN flags err
        clr();
        start_tile(5);
        chk("clr_err", 32'(err), 32'd0);
        feed(2, 500, 0);
        start = 1'b1; num_rows = ADDR_WIDTH'(1);
        cyc();
        start = 1'b0;
        chk("fill_start_no_err", 32'(err), 32'd0);
        chk("fill_start_busy", 32'(busy), 32'd1);
        feed(3, 502, 0);
        in_valid = 1'b1; in_data = mk_row(999);
        cyc();
        in_valid = 1'b0;
        chk("drain_in_valid_err", 32'(err), 32'd1);
        wait_done(40, 1'b0);
        cmp_wr("errs", 5);
        cmp_out("errs");
        chk("errs_err_sticky", 32'(err), 32'd1);

        // Reset in the middle of a drain, then a clean tile
        clr();
        start_tile(6);
        feed(6, 700, 0);
        for (int i = 0; i < 40 && out_log.size() < 2; i++) cyc();
        chk("mid_two_out", 32'(out_log.size()), 32'd2);
        rst_n = 1'b0;
        cyc();
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_rd_addr", 32'(buf_rd_addr), 32'd0);
        chk("mid_rst_wr_addr", 32'(buf_wr_addr), 32'd0);
        chk_row("mid_rst_out_data", out_data, '0);
        rst_n = 1'b1;
        cyc();
        clr();
        start_tile(2);
        feed(2, 800, 0);
        wait_done(30, 1'b0);
        cmp_wr("post_rst", 2);
        cmp_out("post_rst");
        chk("post_rst_done_cnt", 32'(done_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
